fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
Shares the single-port framebuffer BRAM between three users: VGA scanout, the draw engine and a built-in clear-screen sequencer. It sits between vga_controller (px_x/px_y/visible) and the framebuffer. The display is 320x240 logical pixels; each logical pixel spans 2 pixel clocks horizontally and 2 lines vertically (px_y is already line-halved). Scanout has fixed-slot priority and is never stalled; the draw engine and clear sequencer use the remaining slots.

Parameters:
H_RES, 320, logical pixels per line
V_RES, 240, logical lines per frame
ADDR_W, 17, framebuffer word address width (H_RES*V_RES must be <= 2**ADDR_W)
DATA_W, 8, pixel width

Ports:
clk  in  1  system/pixel clock
rst  in  1  synchronous, active-high reset
px_x  in  10  physical column from vga_controller (0..639 visible)
px_y  in  9  logical line from vga_controller (0..239 visible)
visible  in  1  active-video flag from vga_controller
pix_data  out  DATA_W  scanout pixel, registered
pix_valid  out  1  pix_data is a fresh scanout read
drw_valid  in  1  draw request
drw_ready  out  1  draw request accepted this cycle
drw_we  in  1  1=write, 0=read
drw_addr  in  ADDR_W  draw address
drw_wdata  in  DATA_W  draw write data
drw_rvalid  out  1  read data valid pulse
drw_rdata  out  DATA_W  read data
clr_start  in  1  pulse: start clear-screen
clr_color  in  DATA_W  fill colour, sampled on accepted clr_start
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse when clear completes
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data (1-cycle read latency)

Behaviour:
- Scan slot: scan_slot = visible && (px_x[0]==0). Scan address = px_y*H_RES + px_x[9:1], computed as (px_y<<8)+(px_y<<6) for the default H_RES; the general case uses a constant multiply.
- Slot priority per cycle: scan slot > clear sequencer > draw port. mem_* are combinational from this grant; mem_en=0 when no user is granted.
- Draw handshake: drw_ready = drw_valid && !scan_slot && !clr_busy. A transfer occurs when valid && ready. The requester holds its fields stable until ready. drw_rvalid pulses 1 cycle after an accepted read; drw_rdata = mem_rdata in that cycle. Writes produce no response.
- Scanout latency: a scan read in cycle N loads pix_data at the end of N+1, so the pixel is valid in N+2. pix_valid is high for exactly that one cycle; pix_data holds its value until the next load.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE->CLEAR on clr_start: clr_color latched, address counter = 0, clr_busy=1.
  - CLEAR: in each non-scan cycle write clr_color to the counter address, then increment. After writing address H_RES*V_RES-1, go to DONE.
  - DONE: clr_done=1 and clr_busy=0 for one cycle, then IDLE.
  - clr_start in CLEAR or DONE is ignored.
- Simultaneous events: clr_start together with drw_valid in the same cycle → the draw is still accepted that cycle if it is not a scan slot, because clr_busy rises the next cycle.
- A draw read pending when clear begins still returns drw_rvalid.
- Reset: FSM=IDLE; counter=0; pix_data=0, pix_valid=0, drw_rvalid=0, drw_rdata=0, clr_busy=0, clr_done=0. All pending responses are discarded, and a clear in progress is aborted (no clr_done).

Optional Feature:
FB_ARB_STATS_EN
- Defined: adds output stall_cnt [15:0]. It increments each cycle drw_valid && !drw_ready, saturates at 0xFFFF, resets to 0 on rst, and clears on the first cycle of each frame (px_x==0 && px_y==0 && visible).
- Undefined: no port and no counter logic.

Test Plan:
1. Reset → pix_valid=0, clr_busy=0, mem_en=0 with no requests. Release; visible, px_x=0, px_y=0 → mem_addr=0, mem_we=0; pix_valid=1 two cycles later with pix_data = BRAM[0].
2. px_y=1, px_x=6 in visible → mem_addr=323. Next cycle (px_x=7) a pending draw write is accepted (drw_ready=1) and BRAM updated.
3. Draw read addr 0x100 with drw_valid held during a visible even px_x → drw_ready=0. Accepted on the odd cycle; drw_rvalid pulses 1 cycle later with BRAM[0x100].
4. clr_start with clr_color=0x3C during blanking → 76800 writes of 0x3C. clr_done pulses once; drw_ready=0 throughout; spot-check BRAM[0]=BRAM[76799]=0x3C.
5. Clear running during active video → no scan slot is ever lost (pix_valid every other visible cycle). Second clr_start mid-clear is ignored; the write count is still 76800.
6. rst asserted mid-clear → clr_busy=0 next cycle, no clr_done. A new clr_start restarts from address 0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Framebuffer BRAM arbiter: VGA scanout (fixed even-pixel slots) > clear-screen sequencer > draw port.
// Optional FB_ARB_STATS_EN adds a per-frame draw stall counter (stall_cnt).
module fb_port_arbiter #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        px_x,
    input  logic [8:0]        px_y,
    input  logic              visible,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              drw_valid,
    output logic              drw_ready,
    input  logic              drw_we,
    input  logic [ADDR_W-1:0] drw_addr,
    input  logic [DATA_W-1:0] drw_wdata,
    output logic              drw_rvalid,
    output logic [DATA_W-1:0] drw_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} clr_state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              scan_rd_q, scan_rd_d;
    logic              pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              drw_rvalid_q, drw_rvalid_d;

    logic              scan_slot;
    logic              clr_wr;
    logic [ADDR_W-1:0] py_ext;
    logic [ADDR_W-1:0] scan_addr;

    assign py_ext    = ADDR_W'(px_y);
    assign scan_slot = visible && !px_x[0];

    generate
        if (H_RES == 320) begin : g_shift
            assign scan_addr = (py_ext << 8) + (py_ext << 6) + ADDR_W'(px_x[9:1]);
        end else begin : g_mul
            assign scan_addr = py_ext * ADDR_W'(H_RES) + ADDR_W'(px_x[9:1]);
        end
    endgenerate

    always_comb begin
        clr_busy  = (state_q == S_CLEAR);
        clr_done  = (state_q == S_DONE);
        drw_ready = drw_valid && !scan_slot && !clr_busy;
        clr_wr    = clr_busy && !scan_slot;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (scan_slot) begin
            mem_en   = 1'b1;
            mem_addr = scan_addr;
        end else if (clr_wr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = color_q;
        end else if (drw_ready) begin
            mem_en    = 1'b1;
            mem_we    = drw_we;
            mem_addr  = drw_addr;
            mem_wdata = drw_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    color_d = clr_color;
                end
            end
            S_CLEAR: begin
                if (clr_wr) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Scan data lands one cycle after the read, so it is captured at the end of N+1.
    always_comb begin
        scan_rd_d    = scan_slot;
        pix_valid_d  = scan_rd_q;
        pix_data_d   = scan_rd_q ? mem_rdata : pix_data_q;
        drw_rvalid_d = drw_ready && !drw_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            color_q      <= '0;
            scan_rd_q    <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            drw_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            color_q      <= color_d;
            scan_rd_q    <= scan_rd_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            drw_rvalid_q <= drw_rvalid_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign drw_rvalid = drw_rvalid_q;
    assign drw_rdata  = drw_rvalid_q ? mem_rdata : '0;

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (px_x == '0 && px_y == '0 && visible) begin
            stall_d = '0;
        end else if (drw_valid && !drw_ready && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: vector table, directed multi-cycle sequences,
// and randomized traffic against a rule-level reference model with a shadow framebuffer.
module tb_fb_port_arbiter;

    localparam int H    = 320;
    localparam int V    = 8;
    localparam int AW   = 17;
    localparam int DW   = 8;
    localparam int NPIX = H * V;

    logic          clk;
    logic          rst;
    logic [9:0]    px_x;
    logic [8:0]    px_y;
    logic          visible;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          drw_valid;
    logic          drw_ready;
    logic          drw_we;
    logic [AW-1:0] drw_addr;
    logic [DW-1:0] drw_wdata;
    logic          drw_rvalid;
    logic [DW-1:0] drw_rdata;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          clr_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    fb_port_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .px_x(px_x), .px_y(px_y), .visible(visible),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .drw_valid(drw_valid), .drw_ready(drw_ready), .drw_we(drw_we),
        .drw_addr(drw_addr), .drw_wdata(drw_wdata),
        .drw_rvalid(drw_rvalid), .drw_rdata(drw_rdata),
        .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'((i + (i >> 8) * 16 + 11) & 255);
    endfunction

    // Single-port BRAM with 1-cycle read latency; init_go reloads the known pattern.
    logic [7:0] bram [0:4095];
    logic       init_go;
    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < 4096; i++) bram[i] <= pat(i);
        end else if (mem_en) begin
            if (mem_we) bram[mem_addr[11:0]] <= mem_wdata;
            mem_rdata <= bram[mem_addr[11:0]];
        end
    end

    int  wr_cnt, done_cnt, pv_cnt;
    logic mon_clr;
    always @(negedge clk) begin
        if (mon_clr) begin
            wr_cnt   <= 0;
            done_cnt <= 0;
            pv_cnt   <= 0;
        end else begin
            if (mem_en && mem_we && clr_busy) wr_cnt <= wr_cnt + 1;
            if (clr_done) done_cnt <= done_cnt + 1;
            if (pix_valid) pv_cnt <= pv_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        visible = 0; px_x = '0; px_y = '0;
        drw_valid = 0; drw_we = 0; drw_addr = '0; drw_wdata = '0;
        clr_start = 0; clr_color = '0;
    endtask

    task automatic clear_monitors();
        mon_clr = 1;
        tick();
        mon_clr = 0;
    endtask

    typedef struct {
        int vis; int px; int py; int dv;
        int een; int eaddr; int erdy;
    } vec_t;

    // Reference model state for the random phase
    logic [7:0] shadow [0:4095];
    logic [7:0] exp_pix [int];
    logic [7:0] exp_rd [int];

    initial begin
        vec_t tv [10];
        int   n, seen_ready, seen_done, mism;
        bit   s1, s2, sc;

        rst = 1; init_go = 1; mon_clr = 1;
        idle();
        tick(); tick();
        init_go = 0; mon_clr = 0;

        // ---- 1: reset state and first scan read latency
        smp();
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_rvalid", drw_rvalid, 0);
        chk("rst_pix_data", pix_data, 0);
        tick();
        rst = 0; visible = 1; px_x = 0; px_y = 0;
        smp();
        chk("scan0_en", mem_en, 1);
        chk("scan0_addr", mem_addr, 0);
        chk("scan0_we", mem_we, 0);
        tick();
        visible = 0;
        smp();
        chk("scan0_n1_pv", pix_valid, 0);
        tick();
        smp();
        chk("scan0_n2_pv", pix_valid, 1);
        chk("scan0_n2_pd", pix_data, pat(0));
        tick();
        smp();
        chk("scan0_n3_pv", pix_valid, 0);
        chk("scan0_hold_pd", pix_data, pat(0));
        tick();

        // ---- vector table: scan addressing and slot grant
        tv[0] = '{1, 0,   0,   0, 1, 0,     0};
        tv[1] = '{1, 6,   1,   0, 1, 323,   0};
        tv[2] = '{1, 7,   1,   0, 0, 0,     0};
        tv[3] = '{0, 6,   1,   0, 0, 0,     0};
        tv[4] = '{1, 2,   5,   1, 1, 1601,  0};
        tv[5] = '{1, 638, 7,   1, 1, 2559,  0};
        tv[6] = '{1, 100, 3,   0, 1, 1010,  0};
        tv[7] = '{1, 638, 239, 0, 1, 76799, 0};
        tv[8] = '{1, 7,   1,   1, 1, 1234,  1};
        tv[9] = '{0, 0,   0,   1, 1, 1234,  1};
        drw_addr = 17'd1234; drw_we = 0;
        for (int i = 0; i < 10; i++) begin
            visible   = (tv[i].vis != 0);
            px_x      = 10'(tv[i].px);
            px_y      = 9'(tv[i].py);
            drw_valid = (tv[i].dv != 0);
            smp();
            chk($sformatf("vec%0d_en", i), mem_en, tv[i].een);
            chk($sformatf("vec%0d_we", i), mem_we, 0);
            chk($sformatf("vec%0d_rdy", i), drw_ready, tv[i].erdy);
            if (tv[i].een != 0) chk($sformatf("vec%0d_addr", i), mem_addr, tv[i].eaddr);
            tick();
        end
        idle();
        tick(); tick();

        // ---- 2: scan at (6,1) blocks a write that goes through at px_x=7
        visible = 1; px_y = 1; px_x = 6;
        drw_valid = 1; drw_we = 1; drw_addr = 17'd500; drw_wdata = 8'h5A;
        smp();
        chk("t2_scan_addr", mem_addr, 323);
        chk("t2_rdy_blocked", drw_ready, 0);
        tick();
        px_x = 7;
        smp();
        chk("t2_rdy", drw_ready, 1);
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 500);
        tick();
        idle();
        smp();
        chk("t2_bram", bram[500], 8'h5A);
        tick();

        // ---- 3: read held through a scan slot
        visible = 1; px_y = 2; px_x = 10;
        drw_valid = 1; drw_we = 0; drw_addr = 17'h100;
        smp();
        chk("t3_rdy_blocked", drw_ready, 0);
        tick();
        px_x = 11;
        smp();
        chk("t3_rdy", drw_ready, 1);
        chk("t3_addr", mem_addr, 17'h100);
        tick();
        drw_valid = 0; px_x = 12;
        smp();
        chk("t3_rvalid", drw_rvalid, 1);
        chk("t3_rdata", drw_rdata, pat(256));
        tick();
        smp();
        chk("t3_rvalid_pulse", drw_rvalid, 0);
        idle();
        tick();
        clear_monitors();

        // ---- 4: clear in blanking; simultaneous draw read still accepted
        clr_start = 1; clr_color = 8'h3C;
        drw_valid = 1; drw_we = 0; drw_addr = 17'd5;
        smp();
        chk("t4_sim_rdy", drw_ready, 1);
        tick();
        clr_start = 0; clr_color = 8'h00;
        smp();
        chk("t4_busy", clr_busy, 1);
        chk("t4_pending_rvalid", drw_rvalid, 1);
        chk("t4_pending_rdata", drw_rdata, pat(5));
        seen_ready = 0; seen_done = 0;
        for (int c = 0; c < 5000; c++) begin
            smp();
            if (clr_done) begin
                seen_done = 1;
                break;
            end
            if (drw_ready) seen_ready = 1;
            tick();
        end
        chk("t4_done_seen", seen_done, 1);
        chk("t4_busy_at_done", clr_busy, 0);
        chk("t4_ready_during_clear", seen_ready, 0);
        chk("t4_writes", wr_cnt, NPIX);
        drw_valid = 0;
        tick();
        smp();
        chk("t4_done_pulse", clr_done, 0);
        chk("t4_bram0", bram[0], 8'h3C);
        chk("t4_bram_last", bram[NPIX-1], 8'h3C);
        chk("t4_done_cnt", done_cnt, 1);
        idle();
        tick(); tick(); tick();
        clear_monitors();

        // ---- 5: clear under active video, second clr_start ignored
        n = 0; s1 = 0; s2 = 0; mism = 0; seen_done = 0;
        for (int c = 0; c < 8000 && !seen_done; c++) begin
            px_x      = 10'(c % 64);
            visible   = (c % 64) < 40;
            px_y      = 9'((c / 64) % V);
            clr_start = (c == 0) || (c == 1000);
            clr_color = (c == 0) ? 8'h42 : 8'h99;
            sc        = visible && !px_x[0];
            if (sc) n++;
            smp();
            if (pix_valid !== s2) mism++;
            if (clr_done) seen_done = 1;
            s2 = s1; s1 = sc;
            tick();
        end
        idle();
        smp();
        if (pix_valid !== s2) mism++;
        tick();
        smp();
        if (pix_valid !== s1) mism++;
        tick(); tick();
        chk("t5_done_seen", seen_done, 1);
        chk("t5_pix_cadence", mism, 0);
        chk("t5_pix_count", pv_cnt, n);
        chk("t5_writes", wr_cnt, NPIX);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_color_kept", bram[1000], 8'h42);
        clear_monitors();

        // ---- 6: reset aborts clear; restart begins at address 0
        clr_start = 1; clr_color = 8'h11;
        tick();
        clr_start = 0;
        for (int c = 0; c < 100; c++) tick();
        rst = 1;
        tick();
        rst = 0;
        smp();
        chk("t6_busy_after_rst", clr_busy, 0);
        for (int c = 0; c < 3000; c++) tick();
        chk("t6_no_done", done_cnt, 0);
        clr_start = 1; clr_color = 8'h22;
        tick();
        clr_start = 0;
        smp();
        chk("t6_restart_we", mem_we, 1);
        chk("t6_restart_addr", mem_addr, 0);
        chk("t6_restart_data", mem_wdata, 8'h22);
        seen_done = 0;
        for (int c = 0; c < 4000 && !seen_done; c++) begin
            smp();
            if (clr_done) seen_done = 1;
            tick();
        end
        chk("t6_done_seen", seen_done, 1);

        // ---- random traffic against the reference model
        begin
            bit   m_clearing, m_done, req_pend, req_we, rst_i, scan;
            int   m_ptr, req_addr, saddr, e_addr;
            logic [7:0] m_col, req_wd, last_pix, e_wd, e_pd;
            bit   e_en, e_we, e_rdy, e_pv, e_rv;

            idle();
            rst = 1; init_go = 1;
            tick();
            init_go = 0; rst = 0;
            for (int i = 0; i < 4096; i++) shadow[i] = pat(i);
            m_clearing = 0; m_done = 0; m_ptr = 0; m_col = 0;
            req_pend = 0; req_we = 0; req_addr = 0; req_wd = 0;
            last_pix = 0;
            exp_pix.delete(); exp_rd.delete();

            for (int cyc = 0; cyc < 6000; cyc++) begin
                visible   = ($urandom % 4) != 0;
                px_x      = 10'($urandom % 640);
                px_y      = 9'($urandom % V);
                rst_i     = ($urandom % 700) == 0;
                clr_start = (cyc == 100) || (($urandom % 300) == 0);
                clr_color = 8'($urandom);
                if (!req_pend && ($urandom % 3) == 0) begin
                    req_pend = 1;
                    req_we   = $urandom % 2;
                    req_addr = $urandom % NPIX;
                    req_wd   = 8'($urandom);
                end
                rst       = rst_i;
                drw_valid = req_pend;
                drw_we    = req_we;
                drw_addr  = 17'(req_addr);
                drw_wdata = req_wd;

                scan  = visible && (px_x % 2 == 0);
                saddr = int'(px_y) * H + int'(px_x) / 2;
                e_rdy = req_pend && !scan && !m_clearing;
                e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
                if (scan) begin
                    e_en = 1; e_addr = saddr;
                end else if (m_clearing) begin
                    e_en = 1; e_we = 1; e_addr = m_ptr; e_wd = m_col;
                end else if (e_rdy) begin
                    e_en = 1; e_we = req_we; e_addr = req_addr; e_wd = req_wd;
                end
                e_pv = exp_pix.exists(cyc);
                e_pd = e_pv ? exp_pix[cyc] : last_pix;
                e_rv = exp_rd.exists(cyc);

                smp();
                chk("rnd_mem_en", mem_en, e_en);
                if (e_en) begin
                    chk("rnd_mem_addr", mem_addr, e_addr);
                    chk("rnd_mem_we", mem_we, e_we);
                    if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wd);
                end
                chk("rnd_drw_ready", drw_ready, e_rdy);
                chk("rnd_clr_busy", clr_busy, m_clearing);
                chk("rnd_clr_done", clr_done, m_done);
                chk("rnd_pix_valid", pix_valid, e_pv);
                chk("rnd_pix_data", pix_data, e_pd);
                chk("rnd_rvalid", drw_rvalid, e_rv);
                if (e_rv) chk("rnd_rdata", drw_rdata, exp_rd[cyc]);

                // advance the model across the clock edge
                if (scan) exp_pix[cyc+2] = shadow[saddr];
                if (e_rdy && !req_we) exp_rd[cyc+1] = shadow[req_addr];
                if (e_en && e_we) shadow[e_addr] = e_wd;
                last_pix = e_pd;
                if (e_rdy) req_pend = 0;
                if (rst_i) begin
                    m_clearing = 0; m_done = 0; last_pix = 0;
                    exp_pix.delete(cyc+1); exp_pix.delete(cyc+2);
                    exp_rd.delete(cyc+1);
                end else if (m_done) begin
                    m_done = 0;
                end else if (m_clearing) begin
                    if (!scan) begin
                        m_ptr++;
                        if (m_ptr == NPIX) begin
                            m_clearing = 0; m_done = 1;
                        end
                    end
                end else if (clr_start) begin
                    m_clearing = 1; m_ptr = 0; m_col = clr_color;
                end
                tick();
            end
            rst = 0;
            idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
